// File: rtl/rl_force_collector_pkg.sv
// Shared types and constants for the RL force collector: state encoding,
// default widths and the clog2 helper used to validate the index width.
package rl_collect_pkg;

   localparam int DEFAULT_DATA_WIDTH    = 32;
   localparam int DEFAULT_PIPELINE_NUM  = 8;
   localparam int DEFAULT_PIPE_ID_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rl_force_collector_if.sv
// Output stream of the collector: tagged force word with ready/valid handshake.
interface rl_force_collector_if
   import rl_collect_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int PIPE_ID_WIDTH = DEFAULT_PIPE_ID_WIDTH
) ();

   logic [DATA_WIDTH-1:0]    force_out;
   logic [PIPE_ID_WIDTH-1:0] force_out_id;
   logic                     force_out_valid;
   logic                     force_out_ready;

   modport master (
      output force_out,
      output force_out_id,
      output force_out_valid,
      input  force_out_ready
   );

   modport slave (
      input  force_out,
      input  force_out_id,
      input  force_out_valid,
      output force_out_ready
   );

endinterface

// File: rtl/rl_force_collector_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr,
// wrapping modulo REQ_NUM. The pointer register lives in the parent.
module rl_rr_arbiter #(
   parameter int REQ_NUM   = 8,
   parameter int IDX_WIDTH = 3
) (
   input  logic [REQ_NUM-1:0]   req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic [REQ_NUM-1:0]   grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 any_grant
);

   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      j         = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         j = int'(ptr) + k;
         if (j >= REQ_NUM) begin
            j = j - REQ_NUM;
         end
         if (!any_grant && req[j]) begin
            any_grant = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_WIDTH'(j);
         end
      end
   end

endmodule

// File: rtl/rl_force_collector.sv
// Collects one force result per RL pipeline and serialises them round-robin.
// Optional output force_count is enabled by defining RL_FORCE_COLLECT_COUNT_EN.
module rl_force_collector
   import rl_collect_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int PIPELINE_NUM  = DEFAULT_PIPELINE_NUM,
   parameter int PIPE_ID_WIDTH = DEFAULT_PIPE_ID_WIDTH
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic                               pipe_start,
   input  logic [PIPELINE_NUM-1:0]            pipe_done,
   input  logic [PIPELINE_NUM*DATA_WIDTH-1:0] force_in,
   input  logic [PIPELINE_NUM-1:0]            force_in_valid,
   output logic [PIPELINE_NUM-1:0]            force_in_ready,
   rl_force_collector_if.master               out_bus,
   output logic                               busy,
   output logic                               done
`ifdef RL_FORCE_COLLECT_COUNT_EN
   ,
   output logic [31:0]                        force_count
`endif
);

   if (PIPE_ID_WIDTH != clog2(PIPELINE_NUM) || PIPELINE_NUM < 2 || PIPELINE_NUM > 256)
   begin : g_bad_config
      $error("rl_force_collector: illegal PIPELINE_NUM / PIPE_ID_WIDTH combination");
   end

   state_t                   state_reg;
   logic                     pipe_start_reg;
   logic [PIPELINE_NUM-1:0]  sticky_reg;
   logic [PIPELINE_NUM-1:0]  sticky_next;
   logic [PIPELINE_NUM-1:0]  pending_reg;
   logic [PIPELINE_NUM-1:0]  pending_next;
   logic [DATA_WIDTH-1:0]    data_reg [PIPELINE_NUM];
   logic [PIPE_ID_WIDTH-1:0] ptr_reg;
   logic [PIPE_ID_WIDTH-1:0] ptr_next;
   logic [DATA_WIDTH-1:0]    out_data_reg;
   logic [PIPE_ID_WIDTH-1:0] out_id_reg;
   logic                     out_valid_reg;

   logic                     accepting;
   logic                     start_accept;
   logic                     slot_free;
   logic [PIPELINE_NUM-1:0]  arb_grant;
   logic [PIPE_ID_WIDTH-1:0] arb_idx;
   logic                     arb_any;
   logic [PIPELINE_NUM-1:0]  grant_eff;
   logic [PIPELINE_NUM-1:0]  wr;

   assign accepting    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
   assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign slot_free    = !out_valid_reg || out_bus.force_out_ready;

   rl_rr_arbiter #(
      .REQ_NUM   (PIPELINE_NUM),
      .IDX_WIDTH (PIPE_ID_WIDTH)
   ) u_arb (
      .req       (pending_reg),
      .ptr       (ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_grant (arb_any)
   );

   assign grant_eff = slot_free ? arb_grant : '0;
   assign ptr_next  = (int'(arb_idx) == PIPELINE_NUM - 1) ? '0 : arb_idx + 1'b1;

   // An entry being granted this cycle may be refilled on the same edge.
   for (genvar gi = 0; gi < PIPELINE_NUM; gi++) begin : g_entry
      assign force_in_ready[gi] = accepting && (!pending_reg[gi] || grant_eff[gi]);
      assign wr[gi]             = force_in_valid[gi] && force_in_ready[gi];
      assign pending_next[gi]   = wr[gi] || (pending_reg[gi] && !grant_eff[gi]);
      assign sticky_next[gi]    = sticky_reg[gi] || (accepting && pipe_done[gi]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < PIPELINE_NUM; i++) begin
         if (wr[i]) begin
            data_reg[i] <= force_in[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_id_reg    <= '0;
         ptr_reg       <= '0;
      end else if (slot_free) begin
         if (arb_any) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_reg[arb_idx];
            out_id_reg    <= arb_idx;
            ptr_reg       <= ptr_next;
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         pipe_start_reg <= 1'b0;
         sticky_reg     <= '0;
      end else begin
         pipe_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg      <= ST_RUN;
                  pipe_start_reg <= 1'b1;
                  sticky_reg     <= '0;
               end
            end
            ST_RUN: begin
               sticky_reg <= sticky_next;
               if (&sticky_next) begin
                  state_reg <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               sticky_reg <= sticky_next;
               if (!(|pending_reg) && !out_valid_reg && !(|wr)) begin
                  state_reg <= ST_DONE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef RL_FORCE_COLLECT_COUNT_EN
   logic [31:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (start_accept || pipe_start_reg) begin
         count_reg <= '0;
      end else if (out_valid_reg && out_bus.force_out_ready &&
                   (count_reg != 32'hFFFF_FFFF) && (state_reg != ST_DONE)) begin
         count_reg <= count_reg + 32'd1;
      end
   end

   assign force_count = count_reg;
`endif

   assign pipe_start              = pipe_start_reg;
   assign out_bus.force_out       = out_data_reg;
   assign out_bus.force_out_id    = out_id_reg;
   assign out_bus.force_out_valid = out_valid_reg;
   assign busy                    = accepting;
   assign done                    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_rl_force_collector.sv
// Directed scoreboard bench for rl_force_collector: stimulus pushes expected
// (data, id) pairs, a negedge monitor pops them on every output handshake.
module tb_rl_force_collector;

   localparam int DW = 32;
   localparam int PN = 8;
   localparam int IW = 3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             pipe_start;
   logic [PN-1:0]    pipe_done;
   logic [PN*DW-1:0] force_in;
   logic [PN-1:0]    force_in_valid;
   logic [PN-1:0]    force_in_ready;
   logic             busy;
   logic             done;
`ifdef RL_FORCE_COLLECT_COUNT_EN
   logic [31:0]      force_count;
`endif

   rl_force_collector_if #(.DATA_WIDTH(DW), .PIPE_ID_WIDTH(IW)) bus ();

   rl_force_collector #(
      .DATA_WIDTH    (DW),
      .PIPELINE_NUM  (PN),
      .PIPE_ID_WIDTH (IW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pipe_start     (pipe_start),
      .pipe_done      (pipe_done),
      .force_in       (force_in),
      .force_in_valid (force_in_valid),
      .force_in_ready (force_in_ready),
      .out_bus        (bus),
      .busy           (busy),
      .done           (done)
`ifdef RL_FORCE_COLLECT_COUNT_EN
      ,
      .force_count    (force_count)
`endif
   );

   int   checks;
   int   errors;
   exp_t sb_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input int idx, input logic [DW-1:0] value);
      force_in[idx*DW +: DW] = value;
      force_in_valid[idx]    = 1'b1;
      sb_q.push_back('{data: value, id: IW'(idx)});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.force_out_valid && bus.force_out_ready) begin
         $display("[%0t] out data=%08h id=%0d", $time, bus.force_out, bus.force_out_id);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got data=%0h id=%0d, expected no output",
                     bus.force_out, bus.force_out_id);
         end else begin
            e = sb_q.pop_front();
            check("out_data", 64'(bus.force_out), 64'(e.data));
            check("out_id", 64'(bus.force_out_id), 64'(e.id));
         end
      end
   end

   initial begin
      int valid_seen;
      rst                 = 1'b1;
      start               = 1'b0;
      pipe_done           = '0;
      force_in            = '0;
      force_in_valid      = '0;
      bus.force_out_ready = 1'b1;
      checks              = 0;
      errors              = 0;

      tick();
      tick();
      check("rst_valid", 64'(bus.force_out_valid), 64'd0);
      check("rst_pipe_start", 64'(pipe_start), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ready", 64'(force_in_ready), 64'h00);

      rst   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_pulse", 64'(pipe_start), 64'd1);
      check("run_busy", 64'(busy), 64'd1);
      check("run_done", 64'(done), 64'd0);
      check("run_ready", 64'(force_in_ready), 64'hFF);
      tick();
      check("start_pulse_end", 64'(pipe_start), 64'd0);

      // Three simultaneous results, pointer at 0
      present(0, 32'h11);
      present(3, 32'h33);
      present(5, 32'h55);
      tick();
      force_in_valid = '0;
      check("latency_t1", 64'(bus.force_out_valid), 64'd0);
      tick();
      check("latency_t2", 64'(bus.force_out_valid), 64'd1);
      repeat (4) tick();

      // Pointer at 6: 7 must precede 0
      present(7, 32'hA7);
      present(0, 32'hA0);
      sb_q.delete();
      sb_q.push_back('{data: 32'hA7, id: 3'd7});
      sb_q.push_back('{data: 32'hA0, id: 3'd0});
      tick();
      force_in_valid = '0;
      repeat (4) tick();

      present(7, 32'h77);
      tick();
      force_in_valid = '0;
      repeat (4) tick();

      // Pointer wrapped to 0: 0 must precede 7
      present(0, 32'hB0);
      present(7, 32'hB7);
      tick();
      force_in_valid = '0;
      repeat (4) tick();

      // All eight valid with the output stalled
      bus.force_out_ready = 1'b0;
      for (int i = 0; i < PN; i++) present(i, 32'h100 + i);
      tick();
      force_in_valid = '0;
      check("stall_ready_a", 64'(force_in_ready), 64'h01);
      tick();
      for (int c = 0; c < 4; c++) begin
         check("stall_valid", 64'(bus.force_out_valid), 64'd1);
         check("stall_data", 64'(bus.force_out), 64'h100);
         check("stall_id", 64'(bus.force_out_id), 64'd0);
         check("stall_ready", 64'(force_in_ready), 64'h01);
         tick();
      end
      bus.force_out_ready = 1'b1;
      repeat (9) tick();
      check("stall_drained", 64'(bus.force_out_valid), 64'd0);

      // Done pulses while two entries are still pending
      bus.force_out_ready = 1'b0;
      present(2, 32'h22);
      present(4, 32'h44);
      present(6, 32'h66);
      tick();
      force_in_valid = '0;
      tick();
      pipe_done = '1;
      tick();
      pipe_done = '0;
      check("drain_busy", 64'(busy), 64'd1);
      check("drain_done", 64'(done), 64'd0);
      check("drain_ready", 64'(force_in_ready), 64'hAF);
      bus.force_out_ready = 1'b1;
      repeat (3) tick();
      check("drain_last_valid", 64'(bus.force_out_valid), 64'd0);
      check("drain_done_early", 64'(done), 64'd0);
      tick();
      check("done_high", 64'(done), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      check("done_ready", 64'(force_in_ready), 64'h00);
`ifdef RL_FORCE_COLLECT_COUNT_EN
      check("force_count", 64'(force_count), 64'd19);
`endif

      // Restart from DONE, then reset with results in flight
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_pulse", 64'(pipe_start), 64'd1);
      check("restart_done", 64'(done), 64'd0);
`ifdef RL_FORCE_COLLECT_COUNT_EN
      check("count_cleared", 64'(force_count), 64'd0);
`endif
      bus.force_out_ready = 1'b0;
      force_in[1*DW +: DW] = 32'hD1;
      force_in[2*DW +: DW] = 32'hD2;
      force_in[3*DW +: DW] = 32'hD3;
      force_in_valid       = 8'b0000_1110;
      tick();
      force_in_valid = '0;
      tick();
      check("pre_rst_valid", 64'(bus.force_out_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(bus.force_out_valid), 64'd0);
      check("async_rst_data", 64'(bus.force_out), 64'd0);
      check("async_rst_id", 64'(bus.force_out_id), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      tick();
      tick();
      rst                 = 1'b0;
      start               = 1'b1;
      bus.force_out_ready = 1'b1;
      tick();
      start = 1'b0;
      check("post_rst_ready", 64'(force_in_ready), 64'hFF);
`ifdef RL_FORCE_COLLECT_COUNT_EN
      check("post_rst_count", 64'(force_count), 64'd0);
`endif
      valid_seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.force_out_valid) valid_seen++;
         tick();
      end
      check("no_stale_output", 64'(valid_seen), 64'd0);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rl_force_collector.md
Name: rl_force_collector

Overview:
- Sequences and shares one downstream force-accumulation port among PIPELINE_NUM range-limited (RL) force pipelines.
- Issues a common start pulse to the pipelines and buffers one force result per pipeline.
- Serialises buffered results onto a single ready/valid output stream using round-robin arbitration, tagging each result with its pipeline index.
- Reports completion once every pipeline has signalled done and all buffered results have drained.
- Sits between the RL pipeline array and the force accumulator.

Parameters:
- DATA_WIDTH, 32, width of one force word.
- PIPELINE_NUM, 8, number of RL pipelines served; legal range 2..256.
- PIPE_ID_WIDTH, 3, width of the pipeline index; must equal ceil(log2(PIPELINE_NUM)).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; honoured only in IDLE or DONE.
- pipe_start  out  1  one-cycle start pulse broadcast to all pipelines.
- pipe_done  in  PIPELINE_NUM  per-pipeline done level or pulse.
- force_in  in  PIPELINE_NUM*DATA_WIDTH  flat bus; pipeline i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- force_in_valid  in  PIPELINE_NUM  per-pipeline result valid.
- force_in_ready  out  PIPELINE_NUM  per-pipeline accept.
- force_out  out  DATA_WIDTH  selected force word.
- force_out_id  out  PIPE_ID_WIDTH  index of the source pipeline.
- force_out_valid  out  1  output holds a result.
- force_out_ready  in  1  downstream accepts the result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - All holding registers are empty.
  - Done-sticky bits are cleared.
  - Round-robin pointer is 0.
  - State is IDLE.
- Input holding stage: one entry per pipeline (pending[i], data[i]).
  - force_in_ready[i] = ~pending[i] | grant[i], combinational, so a pipeline can refill its entry in the same cycle it drains.
  - A write occurs when force_in_valid[i] & force_in_ready[i].
  - Writes are accepted only in RUN or DRAIN. In IDLE and DONE, force_in_ready is 0.
- Arbitration:
  - Output slot is free when ~force_out_valid | force_out_ready.
  - When the slot is free and any pending bit is set, grant exactly one entry: the first pending index at or above the pointer, wrapping modulo PIPELINE_NUM.
  - On a grant, load force_out/force_out_id from that entry, set force_out_valid, clear the entry's pending bit (unless it is refilled in the same cycle), and set pointer = granted index + 1, wrapping PIPELINE_NUM-1 to 0.
  - Slot free with nothing pending: force_out_valid falls to 0.
  - Output stalled (valid & ~ready): force_out, force_out_id and force_out_valid hold stable.
- Latency and throughput:
  - Input accepted at edge t appears on the output no earlier than cycle t+2.
  - Sustained throughput is 1 result/cycle.
- Done tracking: done_sticky[i] is set when pipe_done[i] is high in RUN or DRAIN, and cleared on leaving DONE or IDLE via start.
- State machine:
  - IDLE: on start, go to RUN, assert pipe_start for exactly one cycle (the first RUN cycle), and clear the stickies.
  - RUN: when all stickies are 1, including bits set this cycle, go to DRAIN.
  - DRAIN: when no entry is pending, force_out_valid is 0, and no write occurs this cycle, go to DONE.
  - DONE: done = 1, held. On start, go to RUN exactly as from IDLE.
  - start in RUN or DRAIN is ignored.
- Late results: a result arriving during DRAIN is accepted and delays DONE.
- Reset mid-operation: all buffered results are discarded immediately, with no output pulse.

Optional Feature:
- Macro: RL_FORCE_COLLECT_COUNT_EN.
- When defined:
  - Adds output force_count [31:0]: the number of output handshakes (force_out_valid & force_out_ready) since the last start.
  - The counter clears when pipe_start is asserted and on reset, saturates at 0xFFFFFFFF, and holds its value in DONE.
- When not defined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package rl_collect_pkg:
  - State encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - Default width constants.
  - A function clog2 used for the PIPE_ID_WIDTH check.
- Sub-module rl_rr_arbiter:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, granted index, any_grant.
  - Purely combinational, instantiated once; the pointer register lives in the parent.

Test Plan:
- Reset, then start: pipe_start is high exactly one cycle, busy = 1, done = 0, all force_in_ready are 1.
- Pipelines 0, 3 and 5 present 0x11, 0x33 and 0x55 in the same cycle, with force_out_ready = 1: outputs appear on consecutive cycles as (0x11,id0), (0x33,id3), (0x55,id5), the first at t+2.
- Pipeline 7 is granted, then pipelines 0 and 7 are both pending: id0 is output before id7, confirming wrap-around and fairness.
- force_out_ready = 0 for 4 cycles while all 8 pipelines are valid:
  - Output holds stable.
  - Every pipeline's ready drops after its first accept.
  - No data is lost; all 8 results emerge once ready returns.
- All pipe_done are pulsed while 2 entries are still pending: state moves to DRAIN, and done rises only the cycle after the last output handshake.
- Reset asserted while 3 results are pending:
  - All outputs go to 0 asynchronously.
  - After release and start, no stale data appears.
  - With RL_FORCE_COLLECT_COUNT_EN, force_count = 0.
